// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED blink scheduler:
//   - rate codes carried on each requester's 2-bit rate slice
//   - scheduler FSM state encoding
//   - counter width used by every phase/period/gap counter
//   - helpers that turn a rate code into a blink period and a LED level
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    RATE_1HZ     = 2'b00,  // period = CLK_HZ
    RATE_HALF    = 2'b01,  // period = 2*CLK_HZ
    RATE_QUARTER = 2'b10,  // period = 4*CLK_HZ
    RATE_SOLID   = 2'b11   // solid on, timed as period CLK_HZ
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Blink period in clock cycles for a rate code; base is CLK_HZ.
  function automatic logic [CNT_W-1:0] rate_period(input logic [1:0] code,
                                                   input logic [CNT_W-1:0] base);
    logic [CNT_W-1:0] period;
    period = base;
    case (code)
      RATE_HALF:    period = base << 1;
      RATE_QUARTER: period = base << 2;
      default:      period = base;
    endcase
    return period;
  endfunction

  // LED level for a given phase: high for the first half of the period
  // (integer half), or always high for the solid code.
  function automatic logic led_level(input logic [1:0] code,
                                     input logic [CNT_W-1:0] phase,
                                     input logic [CNT_W-1:0] base);
    logic [CNT_W-1:0] period;
    period = rate_period(code, base);
    return (code == RATE_SOLID) || (phase < (period >> 1));
  endfunction

endpackage

// File: rtl/led_blink_sched_if.sv
// -----------------------------------------------------------------------------
// led_blink_sched_if
// Request/grant bundle between the system agents and the LED scheduler.
//   req      : per-requester ownership request (level)
//   rate     : per-requester rate code, slice i = rate[2i+1:2i]
//   gnt      : one-hot registered grant
//   done     : one-cycle pulse when the owner completes its full dwell
//   owner_id : index of the current/last owner
// master = agents side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface led_blink_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] rate;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [1:0]        owner_id;

  modport master (
    output req, rate,
    input  gnt, done, owner_id
  );

  modport slave (
    input  req, rate,
    output gnt, done, owner_id
  );
endinterface

// File: rtl/led_blink_gen.sv
// -----------------------------------------------------------------------------
// led_blink_gen
// Blink timing for the current LED owner.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : load rate_in and clear phase/period counters
//   run                : scheduler is in RUN; advance the phase counter
//   led_en             : LED may be lit in the next cycle (next state is RUN)
//   rate_in            : winner's rate code, sampled only on start
//   led                : registered LED level
//   dwell_end          : high during the last cycle of the DWELL-th period
// The led register is computed from the *next* phase so that it lines up
// with the registered grant: both go high on the same edge.
// -----------------------------------------------------------------------------
module led_blink_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DWELL  = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       run,
  input  logic       led_en,
  input  logic [1:0] rate_in,
  output logic       led,
  output logic       dwell_end
);

  localparam logic [CNT_W-1:0] BASE       = CNT_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [1:0]       rate_reg,  rate_next;
  logic [CNT_W-1:0] phase_reg, phase_next;
  logic [CNT_W-1:0] per_reg,   per_next;
  logic             led_reg,   led_next;
  logic [CNT_W-1:0] period_cur;
  logic             last_phase;

  always_comb begin
    period_cur = rate_period(rate_reg, BASE);
    last_phase = (phase_reg == (period_cur - ONE));
    dwell_end  = run && last_phase && (per_reg == DWELL_LAST);

    rate_next  = rate_reg;
    phase_next = phase_reg;
    per_next   = per_reg;

    if (start) begin
      // Rate is latched here only; later rate changes are ignored.
      rate_next  = rate_in;
      phase_next = '0;
      per_next   = '0;
    end else if (run) begin
      if (last_phase) begin
        phase_next = '0;
        per_next   = per_reg + ONE;
      end else begin
        phase_next = phase_reg + ONE;
      end
    end

    led_next = led_en && led_level(rate_next, phase_next, BASE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rate_reg  <= '0;
      phase_reg <= '0;
      per_reg   <= '0;
      led_reg   <= 1'b0;
    end else begin
      rate_reg  <= rate_next;
      phase_reg <= phase_next;
      per_reg   <= per_next;
      led_reg   <= led_next;
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/led_blink_sched.sv
// -----------------------------------------------------------------------------
// led_blink_sched
// Round-robin scheduler sharing one status LED between NREQ requesters.
// The owner gets DWELL full blink periods at its latched rate, then a dark
// gap of GAP_CYCLES, then ownership can pass on.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : req/rate in, gnt/done/owner_id out
//   sw_1               : override switch (LED_SW_OVERRIDE_EN only)
//   led_1              : LED drive
//   led_2              : high while any grant is active
// Optional macro LED_SW_OVERRIDE_EN: sw_1 is synchronised and debounced
// (DEBOUNCE_CYCLES stable) and forces led_1 high while asserted; scheduling
// itself is unaffected. Without the macro sw_1 is ignored.
// NREQ is legal in 2..4 (owner_id is 2 bits wide).
// -----------------------------------------------------------------------------
module led_blink_sched
  import led_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int NREQ            = 3,
  parameter int DWELL           = 2,
  parameter int GAP_CYCLES      = 12500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  led_blink_sched_if.slave  bus,
  input  logic              sw_1,
  output logic              led_1,
  output logic              led_2
);

  localparam logic [1:0]       PTR_INIT = 2'(NREQ - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg,   gnt_next;
  logic [1:0]       owner_reg, owner_next;
  logic [1:0]       ptr_reg,   ptr_next;
  logic [CNT_W-1:0] gap_reg,   gap_next;

  logic [3:0]       req4;
  logic             any_req;
  logic             owner_req;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [NREQ-1:0]  win_onehot;

  logic             start;
  logic             run;
  logic             led_en;
  logic             dwell_end;
  logic             led_sched;

  // Zero-extended copy so a 2-bit index is always in range.
  assign req4      = 4'(bus.req);
  assign any_req   = |bus.req;
  assign owner_req = req4[owner_reg];

  // ---------------------------------------------------------------------------
  // Round-robin search: start one past the last winner and take the first
  // asserted request. A requester holding req is therefore reached again only
  // after every other index has been examined.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(ptr_reg) + k) % NREQ);
      if (!win_found && req4[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign win_onehot[gi] = (win_idx == 2'(gi));
      // dwell_end only occurs in RUN, so only the owner can see done.
      assign bus.done[gi]   = dwell_end && (owner_reg == 2'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> ARB -> RUN -> GAP -> IDLE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    gap_next   = gap_reg;
    start      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_ARB;
        end
      end

      ST_ARB: begin
        // Requests may have vanished since IDLE sampled them.
        if (win_found) begin
          state_next = ST_RUN;
          gnt_next   = win_onehot;
          owner_next = win_idx;
          ptr_next   = win_idx;
          start      = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Either the dwell completed or the owner withdrew; both release
        // the LED on the next edge.
        if (!owner_req || dwell_end) begin
          gnt_next   = '0;
          gap_next   = '0;
          state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign run    = (state_reg == ST_RUN);
  assign led_en = (state_next == ST_RUN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= PTR_INIT;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      gap_reg   <= gap_next;
    end
  end

  led_blink_gen #(
    .CLK_HZ (CLK_HZ),
    .DWELL  (DWELL)
  ) u_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .run       (run),
    .led_en    (led_en),
    .rate_in   (bus.rate[2*win_idx +: 2]),
    .led       (led_sched),
    .dwell_end (dwell_end)
  );

  assign bus.gnt      = gnt_reg;
  assign bus.owner_id = owner_reg;
  assign led_2        = |gnt_reg;

  // ---------------------------------------------------------------------------
  // Optional LED override switch
  // ---------------------------------------------------------------------------
`ifdef LED_SW_OVERRIDE_EN
  localparam logic [CNT_W-1:0] DEB_LAST =
    (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic             sw_meta_reg;
  logic             sw_sync_reg;
  logic             sw_deb_reg;
  logic [CNT_W-1:0] deb_cnt_reg;

  // Two-flop synchroniser, then accept a new level only after it has
  // differed from the debounced value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sw_meta_reg <= 1'b0;
      sw_sync_reg <= 1'b0;
      sw_deb_reg  <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sw_meta_reg <= sw_1;
      sw_sync_reg <= sw_meta_reg;
      if (sw_sync_reg == sw_deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        sw_deb_reg  <= sw_sync_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + ONE;
      end
    end
  end

  assign led_1 = led_sched | sw_deb_reg;
`else
  logic unused_sw;
  assign unused_sw = &{1'b0, sw_1, DEBOUNCE_CYCLES[0]};
  assign led_1     = led_sched;
`endif

endmodule

// File: tb/tb_led_blink_sched.sv
// -----------------------------------------------------------------------------
// tb_led_blink_sched
// Directed bench for led_blink_sched with CLK_HZ=8, NREQ=3, DWELL=2,
// GAP_CYCLES=4, DEBOUNCE_CYCLES=3. Inputs are driven and outputs sampled
// 1 time unit after each rising edge ("slot").
// -----------------------------------------------------------------------------
module tb_led_blink_sched;

  localparam int NREQ = 3;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic sw_1      = 1'b0;
  logic led_1;
  logic led_2;

  int checks   = 0;
  int failures = 0;

  led_blink_sched_if #(.NREQ(NREQ)) bus();

  led_blink_sched #(
    .CLK_HZ          (8),
    .NREQ            (NREQ),
    .DWELL           (2),
    .GAP_CYCLES      (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .sw_1      (sw_1),
    .led_1     (led_1),
    .led_2     (led_2)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns in the slot where reset has just been released.
  task automatic apply_reset();
    sys_rst_n = 1'b0;
    bus.req   = '0;
    bus.rate  = '0;
    sw_1      = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.req   = 3'b111;
    bus.rate  = '0;
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected all zero",
               bus.gnt, bus.done, bus.owner_id, led_1, led_2);
    end
    bus.req   = '0;
    sys_rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if ({bus.gnt, led_1, led_2} !== 5'b0) begin
        failures++;
        $display("FAIL reset_idle_slot%0d: got gnt=%b led1=%b led2=%b, expected 0", j, bus.gnt, led_1, led_2);
      end
    end
    $display("reset: outputs idle");
  endtask

  // req[0], rate 00: 4 high / 4 low x2, done on grant cycle 16, 4-cycle gap.
  task automatic test_single_grant();
    logic exp_led;
    apply_reset();
    bus.rate = 6'b000000;
    bus.req  = 3'b001;
    tick();
    checks++;
    if ({bus.gnt, led_1} !== 4'b0000) begin
      failures++;
      $display("FAIL t1_arb_slot: got gnt=%b led1=%b, expected gnt=000 led1=0", bus.gnt, led_1);
    end
    tick();
    for (int k = 0; k < 16; k++) begin
      exp_led = ((k % 8) < 4);
      checks++;
      if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !==
          {3'b001, (k == 15) ? 3'b001 : 3'b000, 2'd0, exp_led, 1'b1}) begin
        failures++;
        $display("FAIL t1_run_cyc%0d: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected gnt=001 done=%b owner=0 led1=%b led2=1",
                 k + 1, bus.gnt, bus.done, bus.owner_id, led_1, led_2, (k == 15) ? 3'b001 : 3'b000, exp_led);
      end
      if (k == 15) bus.req = 3'b000;
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !== {3'b000, 3'b000, 2'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL t1_after_cyc%0d: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected dark owner=0",
                 j + 17, bus.gnt, bus.done, bus.owner_id, led_1, led_2);
      end
      tick();
    end
    $display("t1 grant owner=0 rate=00 complete");
  endtask

  // req[0] rate 10 and req[2] rate 11 held: owners 0,2,0,2.
  task automatic test_round_robin();
    logic [2:0] oh;
    logic [1:0] own;
    logic       exp_led;
    int         len;
    apply_reset();
    bus.rate = 6'b110010;
    bus.req  = 3'b101;
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      own = (g % 2 == 0) ? 2'd0 : 2'd2;
      oh  = (g % 2 == 0) ? 3'b001 : 3'b100;
      len = (g % 2 == 0) ? 64 : 16;
      for (int k = 0; k < len; k++) begin
        exp_led = (own == 2'd2) ? 1'b1 : ((k % 32) < 16);
        checks++;
        if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !==
            {oh, (k == len - 1) ? oh : 3'b000, own, exp_led, 1'b1}) begin
          failures++;
          $display("FAIL t2_grant%0d_cyc%0d: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected gnt=%b owner=%0d led1=%b",
                   g, k + 1, bus.gnt, bus.done, bus.owner_id, led_1, led_2, oh, own, exp_led);
        end
        tick();
      end
      for (int j = 0; j < 6; j++) begin
        checks++;
        if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !== {6'b0, own, 2'b00}) begin
          failures++;
          $display("FAIL t2_gap%0d_slot%0d: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected dark owner=%0d",
                   g, j, bus.gnt, bus.done, bus.owner_id, led_1, led_2, own);
        end
        tick();
      end
      $display("t2 grant %0d owner=%0d len=%0d", g, own, len);
    end
    bus.req = '0;
  endtask

  // req[1] rate 01 withdrawn mid-RUN: no done, 4-cycle gap, back to IDLE.
  task automatic test_drop();
    apply_reset();
    bus.rate = 6'b000100;
    bus.req  = 3'b010;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.gnt, bus.done, bus.owner_id, led_1} !== {3'b010, 3'b000, 2'd1, 1'b1}) begin
        failures++;
        $display("FAIL t3_run_cyc%0d: got gnt=%b done=%b owner=%0d led1=%b, expected gnt=010 done=000 owner=1 led1=1",
                 k + 1, bus.gnt, bus.done, bus.owner_id, led_1);
      end
      if (k == 5) bus.req = 3'b000;
      tick();
    end
    for (int j = 1; j <= 6; j++) begin
      checks++;
      if ({bus.gnt, bus.done, led_1, led_2} !== 8'b0) begin
        failures++;
        $display("FAIL t3_gap_slot%0d: got gnt=%b done=%b led1=%b led2=%b, expected all 0",
                 j, bus.gnt, bus.done, led_1, led_2);
      end
      if (j == 1) bus.req = 3'b010;
      tick();
    end
    checks++;
    if ({bus.gnt, led_1} !== 4'b0101) begin
      failures++;
      $display("FAIL t3_regrant: got gnt=%b led1=%b, expected gnt=010 led1=1", bus.gnt, led_1);
    end
    bus.req = '0;
    $display("t3 drop owner=1 then regrant");
  endtask

  // Reset mid-RUN of owner 2 with all requests high.
  task automatic test_reset_mid_run();
    int n;
    apply_reset();
    bus.rate = 6'b000000;
    bus.req  = 3'b111;
    n = 0;
    while (bus.gnt !== 3'b100 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 46) begin
      failures++;
      $display("FAIL t4_owner2_arrival: got slot %0d, expected slot 46", n);
    end
    tick();
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.done, bus.owner_id, led_1, led_2} !== 10'b0) begin
      failures++;
      $display("FAIL t4_async_reset: got gnt=%b done=%b owner=%0d led1=%b led2=%b, expected all zero",
               bus.gnt, bus.done, bus.owner_id, led_1, led_2);
    end
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 3'b000) begin
      failures++;
      $display("FAIL t4_post_reset_arb: got gnt=%b, expected 000", bus.gnt);
    end
    tick();
    checks++;
    if ({bus.gnt, bus.owner_id} !== {3'b001, 2'd0}) begin
      failures++;
      $display("FAIL t4_post_reset_grant: got gnt=%b owner=%0d, expected gnt=001 owner=0", bus.gnt, bus.owner_id);
    end
    bus.req = '0;
    $display("t4 reset mid-run, next grant owner=0");
  endtask

  // Rate change during RUN is ignored until the next grant.
  task automatic test_rate_change();
    logic exp_led;
    apply_reset();
    bus.rate = 6'b000000;
    bus.req  = 3'b001;
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      exp_led = ((k % 8) < 4);
      checks++;
      if ({bus.gnt, bus.done, led_1} !== {3'b001, (k == 15) ? 3'b001 : 3'b000, exp_led}) begin
        failures++;
        $display("FAIL t5_first_cyc%0d: got gnt=%b done=%b led1=%b, expected gnt=001 led1=%b",
                 k + 1, bus.gnt, bus.done, led_1, exp_led);
      end
      if (k == 3) bus.rate = 6'b000010;
      tick();
    end
    for (int j = 0; j < 6; j++) tick();
    for (int k = 0; k < 20; k++) begin
      exp_led = ((k % 32) < 16);
      checks++;
      if ({bus.gnt, bus.done, led_1} !== {3'b001, 3'b000, exp_led}) begin
        failures++;
        $display("FAIL t5_second_cyc%0d: got gnt=%b done=%b led1=%b, expected gnt=001 done=000 led1=%b",
                 k + 1, bus.gnt, bus.done, led_1, exp_led);
      end
      tick();
    end
    bus.req = '0;
    $display("t5 rate latched per grant");
  endtask

`ifdef LED_SW_OVERRIDE_EN
  task automatic test_override();
    logic exp_led;
    apply_reset();
    sw_1 = 1'b1;
    tick();
    tick();
    sw_1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (led_1 !== 1'b0) begin
        failures++;
        $display("FAIL t6_short_pulse_slot%0d: got led1=%b, expected 0", j, led_1);
      end
      tick();
    end
    for (int j = 0; j < 13; j++) begin
      if (j == 0) sw_1 = 1'b1;
      if (j == 6) sw_1 = 1'b0;
      exp_led = (j >= 5) && (j <= 10);
      checks++;
      if (led_1 !== exp_led) begin
        failures++;
        $display("FAIL t6_long_pulse_slot%0d: got led1=%b, expected %b", j, led_1, exp_led);
      end
      tick();
    end
    sw_1 = 1'b1;
    for (int j = 0; j < 6; j++) tick();
    bus.rate = 6'b000000;
    bus.req  = 3'b001;
    tick();
    checks++;
    if ({bus.gnt, led_1} !== 4'b0001) begin
      failures++;
      $display("FAIL t6_arb_slot: got gnt=%b led1=%b, expected gnt=000 led1=1", bus.gnt, led_1);
    end
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({bus.gnt, bus.done, led_1} !== {3'b001, (k == 15) ? 3'b001 : 3'b000, 1'b1}) begin
        failures++;
        $display("FAIL t6_forced_cyc%0d: got gnt=%b done=%b led1=%b, expected gnt=001 led1=1",
                 k + 1, bus.gnt, bus.done, led_1);
      end
      tick();
    end
    checks++;
    if (bus.gnt !== 3'b000) begin
      failures++;
      $display("FAIL t6_release_gnt: got gnt=%b, expected 000", bus.gnt);
    end
    bus.req = '0;
    sw_1    = 1'b0;
    $display("t6 override switch");
  endtask
`endif

  initial begin
    bus.req  = '0;
    bus.rate = '0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_drop();
    test_reset_mid_run();
    test_rate_change();
`ifdef LED_SW_OVERRIDE_EN
    test_override();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_blink_sched.md
Name: led_blink_sched

Overview:
Round-robin scheduler that shares the single status LED between NREQ requesters. Each requester asks for ownership via a req/gnt handshake and selects a blink rate. The owner gets DWELL full blink periods, then a dark gap, and ownership passes on. Sits between system agents (boot, link, error monitors) and the led_1/led_2 board pins.

Parameters:
CLK_HZ, 50000000, sys_clk frequency; base blink period in cycles (1 Hz).
NREQ, 3, number of requesters, legal 2..4.
DWELL, 2, full blink periods granted per ownership, >=1.
GAP_CYCLES, 12500000, dark cycles between owners; 0 = no gap.
DEBOUNCE_CYCLES, 1000000, sw_1 stable time (optional feature only).

Ports:
sys_clk  in  1  clock.
sys_rst_n  in  1  reset.
req  in  NREQ  per-requester ownership request, level, held until gnt/done.
rate  in  2*NREQ  per-requester rate code, slice i = rate[2i+1:2i].
sw_1  in  1  override switch (used only with macro).
gnt  out  NREQ  one-hot grant, registered.
done  out  NREQ  one-cycle pulse when owner completes full dwell.
owner_id  out  2  index of current/last owner.
led_1  out  1  LED drive, registered.
led_2  out  1  high while any gnt is high.

Behaviour:
- Reset: sys_rst_n is the reset, asynchronous, active-low; sys_clk is the clock. All outputs 0. State IDLE. RR pointer = NREQ-1, so req[0] wins first.
- Rate codes:
  - 00 = period CLK_HZ.
  - 01 = 2*CLK_HZ.
  - 10 = 4*CLK_HZ.
  - 11 = solid on, timed as period CLK_HZ.
  - Period is computed as CLK_HZ << code[0..2] in 32-bit, no overflow at defaults.
- Blink: 32-bit phase counter 0..period-1. led_1 = 1 while count < period/2 (integer). Solid: led_1 = 1 for the whole dwell. 50% duty.
- FSM IDLE -> ARB -> RUN -> GAP -> IDLE:
  - IDLE: led_1 = 0. If any req, go ARB next cycle.
  - ARB (1 cycle): search from pointer+1 mod NREQ for the first asserted req. Latch the winner's rate, set gnt one-hot, set owner_id and pointer. Clear counters. Go RUN. If req has vanished, return to IDLE, no grant.
  - RUN: gnt and led_1 first high in the same cycle, 2 cycles after req is first sampled in IDLE. Count phase; at period end increment the period counter.
    - At the last cycle of period DWELL: done[owner] pulses that cycle, and gnt drops the next cycle.
    - If req[owner] drops mid-RUN: gnt drops the next cycle, no done, go GAP.
    - rate changes during RUN are ignored.
  - GAP: led_1 = 0 for GAP_CYCLES, then IDLE. GAP_CYCLES = 0 means RUN -> IDLE directly.
- Simultaneous requests are served strictly round-robin. A requester that keeps req high is re-granted only after the others have had their turn.
- Reset mid-RUN/GAP: immediate return to reset values; the next grant goes to the lowest active index.
- done and gnt are never high for a non-owner; at most one gnt bit is high.

Optional Feature:
LED_SW_OVERRIDE_EN:
- Defined: sw_1 passes through a 2-FF synchronizer and a debounce (new value accepted after DEBOUNCE_CYCLES stable). While debounced sw_1 = 1, led_1 is forced 1. Arbitration, gnt, done and timing continue unaffected; release restores the scheduled led_1 on the next cycle.
- Undefined: sw_1 is ignored and no sync/debounce logic exists.

Decomposition:
- Shared package led_pkg:
  - rate code constants RATE_1HZ / RATE_HALF / RATE_QUARTER / RATE_SOLID.
  - FSM state encoding ST_IDLE / ST_ARB / ST_RUN / ST_GAP.
  - Counter width constant 32.
- One sub-module led_blink_gen: phase and period counters, period/half computation, led level, and a dwell_end strobe. Inputs are start, latched rate, and DWELL.
- The top module holds the FSM, RR arbiter and optional debounce.

Test Plan:
Sim params: CLK_HZ=8, DWELL=2, GAP_CYCLES=4, NREQ=3.
1. req[0]=1 from IDLE, rate 00 -> gnt[0] and led_1 high 2 cycles later; led pattern 4 high/4 low x2; done[0] on cycle 16 of grant; gnt[0] low at cycle 17; then 4 cycles led 0.
2. req[0] and req[2] held, rates 10/11 -> owners 0,2,0,2; owner 0: 16 high/16 low x2; owner 2: led high 16 contiguous; no gnt overlap.
3. req[1] rate 01, dropped 5 cycles into RUN -> gnt[1] low next cycle, done never pulses, 4-cycle gap, return to IDLE.
4. sys_rst_n low mid-RUN of owner 2 with req[0..2] all high -> gnt, done, led_1, led_2, owner_id 0 immediately; after release gnt[0] first.
5. Change rate[1:0] 00->10 during RUN -> period stays 8 until the next grant.
6. (LED_SW_OVERRIDE_EN, DEBOUNCE_CYCLES=3) sw_1 high 2 cycles -> no effect; sw_1 high 6 cycles -> led_1 forced 1 after sync+debounce; gnt sequence identical to the run without the macro.
